// File: rtl/ex_stage_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================
// Package : ex_stage_pkg
// Brief   : Bus widths, ALU/operand-select bit indices, MIPS
//           function codes and divider state encodings.
// Rev     : 1.0 - initial release
// ============================================================
package ex_stage_pkg;

  localparam int c_id_to_ex_wd  = 159;
  localparam int c_ex_to_mem_wd = 76;
  localparam int c_ex_to_rf_wd  = 38;
  localparam int c_hilo_wd      = 65;
  localparam int c_stall_wd     = 6;

  localparam logic c_stop    = 1'b1;
  localparam logic c_no_stop = 1'b0;

  localparam int c_alu_add  = 11;
  localparam int c_alu_sub  = 10;
  localparam int c_alu_slt  = 9;
  localparam int c_alu_sltu = 8;
  localparam int c_alu_and  = 7;
  localparam int c_alu_nor  = 6;
  localparam int c_alu_or   = 5;
  localparam int c_alu_xor  = 4;
  localparam int c_alu_sll  = 3;
  localparam int c_alu_srl  = 2;
  localparam int c_alu_sra  = 1;
  localparam int c_alu_lui  = 0;

  localparam int c_src1_rs    = 0;
  localparam int c_src1_pc    = 1;
  localparam int c_src1_sa    = 2;
  localparam int c_src2_rt    = 0;
  localparam int c_src2_simm  = 1;
  localparam int c_src2_eight = 2;
  localparam int c_src2_zimm  = 3;

  localparam logic [5:0] c_func_mult  = 6'h18;
  localparam logic [5:0] c_func_multu = 6'h19;
  localparam logic [5:0] c_func_div   = 6'h1A;
  localparam logic [5:0] c_func_divu  = 6'h1B;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  sel_src1;
    logic [3:0]  sel_src2;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
  } id_to_ex_t;

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_stage_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================
// Interface : ex_stage_if
// Brief     : Data-SRAM request bus driven by the execute stage.
// Rev       : 1.0 - initial release
// ============================================================
interface ex_stage_if;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;

  modport master (output en, wen, addr, wdata);
  modport slave  (input  en, wen, addr, wdata);
endinterface
`default_nettype wire

// File: rtl/ex_stage_div_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================
// Module : div_iter
// Brief  : Iterative restoring divider, one quotient bit per
//          cycle, signed or unsigned operands.
// Rev    : 1.0 - initial release
// ============================================================
module div_iter
  import ex_stage_pkg::*;
#(
  parameter int DIV_STEPS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic        advance,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam int c_cnt_w = $clog2(DIV_STEPS + 1);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DIV_STEPS - 1);

  div_state_t         r_state;
  div_state_t         w_state_d;
  logic [c_cnt_w-1:0] r_count;
  logic [31:0]        r_rem;
  logic [31:0]        r_quo;
  logic [31:0]        r_divisor;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dbz;
  logic               r_done_seen;

  logic [32:0]        w_trial;
  logic [32:0]        w_diff;
  logic               w_fits;

  always_ff @(posedge clk) begin
    if (rst) r_state <= DIV_IDLE;
    else     r_state <= w_state_d;
  end

  // DONE waits for the EX register to move on so the same DIV is not re-run.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      DIV_IDLE: if (start)            w_state_d = DIV_RUN;
      DIV_RUN:  if (r_count == c_last) w_state_d = DIV_DONE;
      DIV_DONE: if (advance)          w_state_d = DIV_IDLE;
      default:                        w_state_d = DIV_IDLE;
    endcase
  end

  always_comb begin
    busy = ((r_state == DIV_IDLE) && start) || (r_state == DIV_RUN);
    done = (r_state == DIV_DONE) && !r_done_seen;
  end

  assign w_trial = {r_rem, r_quo[31]};
  assign w_diff  = w_trial - {1'b0, r_divisor};
  assign w_fits  = (w_trial >= {1'b0, r_divisor});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_divisor   <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_dbz       <= 1'b0;
      r_done_seen <= 1'b0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          r_done_seen <= 1'b0;
          if (start) begin
            r_count   <= '0;
            r_rem     <= '0;
            r_quo     <= abs32(a, signed_op);
            r_divisor <= abs32(b, signed_op);
            r_neg_q   <= signed_op & (a[31] ^ b[31]);
            r_neg_r   <= signed_op & a[31];
            r_dbz     <= (b == 32'd0);
          end
        end
        DIV_RUN: begin
          r_count <= r_count + 1'b1;
          r_rem   <= w_fits ? w_diff[31:0] : w_trial[31:0];
          r_quo   <= {r_quo[30:0], w_fits};
        end
        DIV_DONE: r_done_seen <= 1'b1;
        default: ;
      endcase
    end
  end

  assign quotient  = r_dbz   ? 32'hFFFF_FFFF
                   : r_neg_q ? (32'd0 - r_quo) : r_quo;
  assign remainder = r_neg_r ? (32'd0 - r_rem) : r_rem;

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================
// Module : ex_stage
// Brief  : MIPS execute stage: EX register, 12-op ALU, data-SRAM
//          request, forward bus, iterative DIV/DIVU.
//          Optional MULT/MULTU under macro EX_MUL_EN.
// Rev    : 1.0 - initial release
// ============================================================
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DIV_STEPS = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [c_stall_wd-1:0]     stall,
  input  logic [c_id_to_ex_wd-1:0]  id_to_ex_bus,
  output logic [c_ex_to_mem_wd-1:0] ex_to_mem_bus,
  output logic [c_ex_to_rf_wd-1:0]  ex_to_rf_bus,
  ex_stage_if.master                data_sram,
  output logic                      hilo_we,
  output logic [63:0]               hilo_wdata,
  output logic                      stallreq_for_ex
);

  id_to_ex_t   r_bus;
  logic [31:0] w_src1;
  logic [31:0] w_src2;
  logic [31:0] w_result;
  logic [31:0] w_simm;
  logic [31:0] w_zimm;
  logic [5:0]  w_opcode;
  logic [5:0]  w_func;
  logic        w_is_div;
  logic        w_div_signed;
  logic        w_ex_advance;
  logic        w_div_busy;
  logic        w_div_done;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic        w_mul_we;
  logic [63:0] w_product;

  always_ff @(posedge clk) begin
    if (rst)
      r_bus <= '0;
    else if (stall[2] == c_stop && stall[3] == c_no_stop)
      r_bus <= '0;
    else if (stall[2] == c_no_stop)
      r_bus <= id_to_ex_bus;
  end

  assign w_ex_advance = !(stall[2] == c_stop && stall[3] == c_stop);
  assign w_simm       = {{16{r_bus.inst[15]}}, r_bus.inst[15:0]};
  assign w_zimm       = {16'd0, r_bus.inst[15:0]};
  assign w_opcode     = r_bus.inst[31:26];
  assign w_func       = r_bus.inst[5:0];

  always_comb begin
    w_src1 = '0;
    if (r_bus.sel_src1[c_src1_rs])    w_src1 = w_src1 | r_bus.rdata1;
    if (r_bus.sel_src1[c_src1_pc])    w_src1 = w_src1 | r_bus.pc;
    if (r_bus.sel_src1[c_src1_sa])    w_src1 = w_src1 | {27'd0, r_bus.inst[10:6]};
    w_src2 = '0;
    if (r_bus.sel_src2[c_src2_rt])    w_src2 = w_src2 | r_bus.rdata2;
    if (r_bus.sel_src2[c_src2_simm])  w_src2 = w_src2 | w_simm;
    if (r_bus.sel_src2[c_src2_eight]) w_src2 = w_src2 | 32'd8;
    if (r_bus.sel_src2[c_src2_zimm])  w_src2 = w_src2 | w_zimm;
  end

  always_comb begin
    w_result = '0;
    if (r_bus.alu_op[c_alu_add])  w_result = w_result | (w_src1 + w_src2);
    if (r_bus.alu_op[c_alu_sub])  w_result = w_result | (w_src1 - w_src2);
    if (r_bus.alu_op[c_alu_slt])  w_result = w_result | {31'd0, $signed(w_src1) < $signed(w_src2)};
    if (r_bus.alu_op[c_alu_sltu]) w_result = w_result | {31'd0, w_src1 < w_src2};
    if (r_bus.alu_op[c_alu_and])  w_result = w_result | (w_src1 & w_src2);
    if (r_bus.alu_op[c_alu_nor])  w_result = w_result | ~(w_src1 | w_src2);
    if (r_bus.alu_op[c_alu_or])   w_result = w_result | (w_src1 | w_src2);
    if (r_bus.alu_op[c_alu_xor])  w_result = w_result | (w_src1 ^ w_src2);
    if (r_bus.alu_op[c_alu_sll])  w_result = w_result | (w_src2 << w_src1[4:0]);
    if (r_bus.alu_op[c_alu_srl])  w_result = w_result | (w_src2 >> w_src1[4:0]);
    if (r_bus.alu_op[c_alu_sra])  w_result = w_result | 32'($signed(w_src2) >>> w_src1[4:0]);
    if (r_bus.alu_op[c_alu_lui])  w_result = w_result | (w_src2 << 16);
  end

  assign ex_to_mem_bus = {r_bus.pc, r_bus.ram_en, r_bus.ram_wen, r_bus.sel_rf_res,
                          r_bus.rf_we, r_bus.rf_waddr, w_result};
  assign ex_to_rf_bus  = {r_bus.rf_we, r_bus.rf_waddr, w_result};

  assign data_sram.en    = r_bus.ram_en;
  assign data_sram.wen   = r_bus.ram_wen;
  assign data_sram.addr  = w_result;
  assign data_sram.wdata = r_bus.rdata2;

  assign w_is_div     = (w_opcode == 6'd0) && (w_func == c_func_div || w_func == c_func_divu);
  assign w_div_signed = (w_func == c_func_div);

  div_iter #(
    .DIV_STEPS (DIV_STEPS)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (w_is_div),
    .signed_op (w_div_signed),
    .advance   (w_ex_advance),
    .a         (r_bus.rdata1),
    .b         (r_bus.rdata2),
    .busy      (w_div_busy),
    .done      (w_div_done),
    .quotient  (w_quo),
    .remainder (w_rem)
  );

`ifdef EX_MUL_EN
  logic [63:0] w_mul_a;
  logic [63:0] w_mul_b;
  logic        w_mul_signed;
  assign w_mul_we     = (w_opcode == 6'd0) && (w_func == c_func_mult || w_func == c_func_multu);
  assign w_mul_signed = (w_func == c_func_mult);
  // Low 64 bits of the extended product are exact for both signednesses.
  assign w_mul_a      = {{32{w_mul_signed & r_bus.rdata1[31]}}, r_bus.rdata1};
  assign w_mul_b      = {{32{w_mul_signed & r_bus.rdata2[31]}}, r_bus.rdata2};
  assign w_product    = w_mul_a * w_mul_b;
`else
  assign w_mul_we     = 1'b0;
  assign w_product    = '0;
`endif

  // Gating with rst drops the hold request in the reset cycle itself.
  assign stallreq_for_ex = w_div_busy & ~rst;
  assign hilo_we         = (w_div_done | w_mul_we) & ~rst;
  assign hilo_wdata      = !hilo_we  ? 64'd0
                         : w_mul_we  ? w_product
                         : {w_rem, w_quo};

  logic unused_ok;
  assign unused_ok = &{1'b0, stall[5:4], stall[1:0], r_bus.inst[25:16]};

endmodule
`default_nettype wire

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. It sits between the decode stage and the memory stage.
- Registers the decode-to-execute bus and runs the 12-op ALU on the selected operands.
- Issues data-SRAM requests for loads and stores, and forwards its result to decode.
- Runs DIV/DIVU on an iterative 32-step divider. It holds the pipeline via stallreq_for_ex until the quotient and remainder reach HI/LO.

Parameters:
- DIV_STEPS, 32, number of divider iterations (one quotient bit per cycle).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high; clock clk
- stall  in  `StallBus (6)  pipeline stall vector; bit 2 = ID, bit 3 = EX
- id_to_ex_bus  in  `ID_TO_EX_WD (159)  {pc32, inst32, alu_op12, sel_src1 3, sel_src2 4, ram_en1, ram_wen4, rf_we1, rf_waddr5, sel_rf_res1, rdata1 32, rdata2 32}
- ex_to_mem_bus  out  `EX_TO_MEM_WD (76)  {pc32, ram_en1, ram_wen4, sel_rf_res1, rf_we1, rf_waddr5, ex_result32}
- ex_to_rf_bus  out  `EX_TO_RF_WD (38)  {rf_we, rf_waddr, ex_result}; forward path to decode
- data_sram_en  out  1  data RAM enable
- data_sram_wen  out  4  byte write enables
- data_sram_addr  out  32  ALU result
- data_sram_wdata  out  32  rdata2
- hilo_we  out  1  HI/LO write strobe
- hilo_wdata  out  64  {hi = remainder, lo = quotient}
- stallreq_for_ex  out  1  hold request to the stall controller

Behaviour:
- Input register update, each posedge:
  - rst: clear to 0.
  - stall[2]=Stop and stall[3]=NoStop: clear to 0 (bubble).
  - stall[2]=NoStop: latch id_to_ex_bus.
  - Otherwise hold.
- Operand 1 selection (one-hot sel_src1): [0] rdata1; [1] pc; [2] zero-extended sa (inst[10:6]). No select bit set → 0.
- Operand 2 selection (one-hot sel_src2): [0] rdata2; [1] sign-extended imm; [2] 32'd8; [3] zero-extended imm. No select bit set → 0.
- ALU ops, alu_op bits 11..0 = add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui:
  - add/sub: 32-bit wrap-around, no overflow trap.
  - slt: signed compare; sltu: unsigned compare; result is 0 or 1.
  - Shifts: shift src2 by src1[4:0].
  - lui: src2 << 16.
  - No op bit set → result 0.
- Combinational outputs, no latency from the registered bus: ex_result, data_sram_*, ex_to_mem_bus, ex_to_rf_bus.
- DIV decode: inst opcode 0, func 0x1A is DIV (signed), func 0x1B is DIVU.
- Divider FSM states IDLE, RUN, DONE; reset → IDLE.
  - IDLE with div in EX: capture absolute operands and the sign flags, count = 0, go to RUN. stallreq = 1.
  - RUN: one restoring subtract-shift per cycle; count += 1; leave for DONE after DIV_STEPS cycles. stallreq = 1.
  - DONE: apply signs (quotient negated if the operand signs differ; remainder takes the dividend's sign). Pulse hilo_we = 1 for one cycle. stallreq = 0. Go to IDLE.
  - DONE → IDLE also requires the EX register to have advanced, so the same division is not restarted.
- Division latency: div enters EX at cycle T → stallreq high for T..T+32 (33 cycles) → hilo_we at T+33.
- Divide by zero: quotient 32'hFFFFFFFF, remainder = dividend. Runs the full length; no exception.
- Signed overflow case (0x80000000 / -1): quotient 0x80000000, remainder 0.
- rst during RUN: FSM → IDLE; stallreq and hilo_we go to 0 in the same cycle; partial result discarded.
- A div that becomes a bubble (flushed to 0) is never decoded, so no division starts.
- Reset values: every output is 0, including hilo_we and stallreq_for_ex.

Optional Feature:
- Macro EX_MUL_EN.
- Defined: MULT (func 0x18) and MULTU (0x19) compute a 64-bit product combinationally. They assert hilo_we in the EX cycle with {hi, lo} = product; no stall.
- Undefined: MULT/MULTU behave as NOPs, with hilo_we = 0 and no stall.

Decomposition:
- Shared constants in lib/defines.vh:
  - EX_TO_MEM_WD = 76, EX_TO_RF_WD = 38, HILO_WD = 65.
  - alu_op bit indices; sel_src bit indices.
  - Divider state encodings: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
  - Stop/NoStop already exist in that file.
- One sub-module, div_iter: handshake {start, signed_op, a, b} → {busy, done pulse, quotient, remainder}.
- ALU and operand muxes stay inline.

Test Plan:
- ORI: rs = 0x00001234, imm = 0x8000, sel_src2[3], op_or → ex_result 0x00009234, rf_we forwarded on ex_to_rf_bus the same cycle.
- LUI then ADDIU:
  - LUI with imm 0xABCD → ex_result 0xABCD0000.
  - ADDIU with rs 0xFFFFFFFF, imm 0x0001 → 0x00000000 (wrap-around).
- SW: rs = 0x1000, imm = 4, ram_en = 1, wen = 4'hF, rt = 0xDEADBEEF → data_sram_addr 0x1004, wdata 0xDEADBEEF, en 1, wen 4'hF.
- DIV signed, -7 / 2:
  - stallreq high for 33 cycles.
  - hilo_we pulse with lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1).
  - DIVU 7 / 0: lo = 0xFFFFFFFF, hi = 7.
- rst asserted 10 cycles into a DIV → next cycle stallreq 0 and hilo_we 0. A following DIVU 100 / 7 gives lo = 14, hi = 2.
- Bubble: stall[2] = Stop, stall[3] = NoStop → ex_to_mem_bus all zeros, data_sram_en 0, rf_we 0.
